// File: rtl/ppu_ctrl_pipeline.sv
// Post-ID control pipeline for the PPU core. It carries ctrl/rd/valid through N_STAGES,
// inserts load-use bubbles, applies flush and freeze, and produces forwarding selects.
module ppu_ctrl_pipeline #(
  parameter int CTRL_W   = 27,
  parameter int N_STAGES = 3,
  parameter int LOAD_BIT = 0,
  parameter int RFEN_BIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [CTRL_W-1:0]            id_ctrl,
  input  logic                         id_valid,
  input  logic [4:0]                   id_rd,
  input  logic [4:0]                   id_rs1,
  input  logic [4:0]                   id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         flush,
  input  logic                         ext_stall,
  output logic [N_STAGES*CTRL_W-1:0]   stg_ctrl,
  output logic [N_STAGES*5-1:0]        stg_rd,
  output logic [N_STAGES-1:0]          stg_valid,
  output logic                         pc_le,
  output logic                         if_id_le,
  output logic                         if_id_clr,
  output logic                         nop_sel,
  output logic [1:0]                   fwd_a,
  output logic [1:0]                   fwd_b,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int FWD_N = (N_STAGES < 3) ? N_STAGES : 3;

  // Per-cycle pipeline action, decided by priority Reset > freeze > flush > bubble > run.
  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_FLUSH,
    MODE_BUBBLE,
    MODE_RUN
  } mode_e;

  mode_e               mode;
  logic                hazard;
  logic [CTRL_W-1:0]   ctrl_q [N_STAGES];
  logic [CTRL_W-1:0]   ctrl_d [N_STAGES];
  logic [4:0]          rd_q   [N_STAGES];
  logic [4:0]          rd_d   [N_STAGES];
  logic [N_STAGES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    hazard = id_valid & valid_q[0] & ctrl_q[0][LOAD_BIT] & (rd_q[0] != 5'd0) &
             ((id_use_rs1 & (id_rs1 == rd_q[0])) | (id_use_rs2 & (id_rs2 == rd_q[0])));
  end

  always_comb begin
    if (Reset)          mode = MODE_RESET;
    else if (ext_stall) mode = MODE_FREEZE;
    else if (flush)     mode = MODE_FLUSH;
    else if (hazard)    mode = MODE_BUBBLE;
    else                mode = MODE_RUN;
  end

  always_comb begin
    pc_le     = 1'b1;
    if_id_le  = 1'b1;
    if_id_clr = 1'b0;
    nop_sel   = 1'b0;
    unique case (mode)
      MODE_RESET:  begin pc_le = 1'b0; if_id_le = 1'b0; if_id_clr = 1'b1; nop_sel = 1'b1; end
      MODE_FREEZE: begin pc_le = 1'b0; if_id_le = 1'b0; end
      MODE_FLUSH:  begin if_id_clr = 1'b1; nop_sel = 1'b1; end
      MODE_BUBBLE: begin pc_le = 1'b0; if_id_le = 1'b0; nop_sel = 1'b1; end
      default:     ;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (mode == MODE_FLUSH || mode == MODE_BUBBLE || mode == MODE_RUN) begin
      for (int k = 1; k < N_STAGES; k++) begin
        ctrl_d[k]  = ctrl_q[k-1];
        rd_d[k]    = rd_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      if (mode == MODE_RUN) begin
        ctrl_d[0]  = id_ctrl;
        rd_d[0]    = id_rd;
        valid_d[0] = id_valid;
      end else begin
        ctrl_d[0]  = '0;
        rd_d[0]    = '0;
        valid_d[0] = 1'b0;
      end
    end
    if (mode == MODE_BUBBLE && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int k = 0; k < N_STAGES; k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        rd_q[k]   <= rd_d[k];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Descending scan so the youngest matching stage wins; a load in EX is left to the bubble.
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (!Reset) begin
      for (int k = FWD_N - 1; k >= 0; k--) begin
        if (valid_q[k] && ctrl_q[k][RFEN_BIT] && (rd_q[k] != 5'd0) &&
            (k != 0 || !ctrl_q[0][LOAD_BIT])) begin
          if (rd_q[k] == id_rs1) fwd_a = 2'(k + 1);
          if (rd_q[k] == id_rs2) fwd_b = 2'(k + 1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_pack
    assign stg_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
    assign stg_rd[g*5 +: 5]             = rd_q[g];
  end
  assign stg_valid = valid_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ppu_ctrl_pipeline.sv
// Bench for ppu_ctrl_pipeline: directed load-use/forward/flush/freeze/saturation scenarios
// plus random traffic, all checked against a queue-based reference model.
module tb_ppu_ctrl_pipeline;
  localparam int CTRL_W = 27;
  localparam int N      = 3;
  localparam int LB     = 0;
  localparam int RB     = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Reset, id_valid, id_use_rs1, id_use_rs2, flush, ext_stall;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rd, id_rs1, id_rs2;

  logic [N*CTRL_W-1:0] stg_ctrl, s_stg_ctrl;
  logic [N*5-1:0]      stg_rd, s_stg_rd;
  logic [N-1:0]        stg_valid, s_stg_valid;
  logic                pc_le, if_id_le, if_id_clr, nop_sel;
  logic                s_pc_le, s_if_id_le, s_if_id_clr, s_nop_sel;
  logic [1:0]          fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [15:0]         stall_cnt;
  logic [3:0]          s_stall_cnt;

  ppu_ctrl_pipeline dut (
    .clk(clk), .Reset(Reset), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .flush(flush), .ext_stall(ext_stall), .stg_ctrl(stg_ctrl), .stg_rd(stg_rd),
    .stg_valid(stg_valid), .pc_le(pc_le), .if_id_le(if_id_le), .if_id_clr(if_id_clr),
    .nop_sel(nop_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  ppu_ctrl_pipeline #(.CNT_W(4)) dut_sat (
    .clk(clk), .Reset(Reset), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .flush(flush), .ext_stall(ext_stall), .stg_ctrl(s_stg_ctrl), .stg_rd(s_stg_rd),
    .stg_valid(s_stg_valid), .pc_le(s_pc_le), .if_id_le(s_if_id_le), .if_id_clr(s_if_id_clr),
    .nop_sel(s_nop_sel), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
  );

  // reference model: stage 0 at the front of the queue
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              v;
  } stage_t;

  stage_t      pipe_q[$];
  int unsigned cnt16, cnt4;
  int          cyc, n_checks, n_errors;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic m_hazard();
    stage_t s0 = pipe_q[0];
    if (!id_valid || !s0.v || !s0.ctrl[LB] || s0.rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == s0.rd) || (id_use_rs2 && id_rs2 == s0.rd);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (Reset || rs == 5'd0) return 2'd0;
    for (int k = 0; k < N && k < 3; k++) begin
      if (pipe_q[k].v && pipe_q[k].ctrl[RB] && pipe_q[k].rd == rs &&
          !(k == 0 && pipe_q[k].ctrl[LB]))
        return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic check_all();
    logic [N*CTRL_W-1:0] ec;
    logic [N*5-1:0]      er;
    logic [N-1:0]        ev;
    logic [3:0]          eo;   // {pc_le, if_id_le, if_id_clr, nop_sel}
    for (int k = 0; k < N; k++) begin
      ec[k*CTRL_W +: CTRL_W] = pipe_q[k].ctrl;
      er[k*5 +: 5]           = pipe_q[k].rd;
      ev[k]                  = pipe_q[k].v;
    end
    if (Reset)           eo = 4'b0011;
    else if (ext_stall)  eo = 4'b0000;
    else if (flush)      eo = 4'b1111;
    else if (m_hazard()) eo = 4'b0001;
    else                 eo = 4'b1100;
    chk("stg_ctrl", stg_ctrl, ec);
    chk("stg_rd", stg_rd, er);
    chk("stg_valid", stg_valid, ev);
    chk("pc_le", pc_le, eo[3]);
    chk("if_id_le", if_id_le, eo[2]);
    chk("if_id_clr", if_id_clr, eo[1]);
    chk("nop_sel", nop_sel, eo[0]);
    chk("fwd_a", fwd_a, m_fwd(id_rs1));
    chk("fwd_b", fwd_b, m_fwd(id_rs2));
    chk("stall_cnt", stall_cnt, cnt16);
    chk("stall_cnt_w4", s_stall_cnt, cnt4);
  endtask

  task automatic model_update();
    stage_t nxt;
    logic   haz;
    if (Reset) begin
      pipe_q.delete();
      for (int k = 0; k < N; k++) pipe_q.push_back('0);
      cnt16 = 0;
      cnt4  = 0;
    end else if (!ext_stall) begin
      haz = m_hazard();
      nxt = (flush || haz) ? stage_t'('0) : '{ctrl: id_ctrl, rd: id_rd, v: id_valid};
      pipe_q.push_front(nxt);
      void'(pipe_q.pop_back());
      if (!flush && haz) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [CTRL_W-1:0] mk(input logic ld, input logic rf);
    logic [CTRL_W-1:0] c;
    c     = CTRL_W'($urandom);
    c[LB] = ld;
    c[RB] = rf;
    return c;
  endfunction

  task automatic put(input logic [CTRL_W-1:0] c, input logic v, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
    Reset = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    id_ctrl = c; id_valid = v; id_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  initial begin
    int snap;
    n_checks = 0; n_errors = 0; cyc = 0; cnt16 = 0; cnt4 = 0;
    for (int k = 0; k < N; k++) pipe_q.push_back('0);
    put('0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();

    // reset with instructions in flight
    for (int i = 0; i < 5; i++) begin
      put(mk(1'b0, 1'b1), 1'b1, 5'(10 + i), 5'd0, 5'd0, 1'b0, 1'b0);
      step();
    end
    Reset = 1'b1;
    step();
    put(mk(1'b0, 1'b0), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("rst_valid", stg_valid, 0);
    chk("rst_rd", stg_rd, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_pc_le", pc_le, 1);
    step();

    // load-use: LW x5 ; ADD x6,x5,x1
    put(mk(1'b1, 1'b1), 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
    settle();
    chk("lu_pc_le", pc_le, 0);
    chk("lu_nop_sel", nop_sel, 1);
    step();
    settle();
    chk("lu_bubble", stg_valid[0], 0);
    chk("lu_fwd_a", fwd_a, 2);
    chk("lu_cnt", stall_cnt, 1);
    step();

    // forwarding from EX; x0 never forwards
    put(mk(1'b0, 1'b1), 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1);
    settle();
    chk("fw_a", fwd_a, 1);
    chk("fw_b", fwd_b, 1);
    chk("fw_pc_le", pc_le, 1);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1);
    settle();
    chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);
    step();

    // flush with older instructions in flight
    put(mk(1'b0, 1'b1), 1'b1, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd21, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd22, 5'd1, 5'd2, 1'b1, 1'b1);
    flush = 1'b1;
    settle();
    chk("fl_clr", if_id_clr, 1);
    chk("fl_pc_le", pc_le, 1);
    chk("fl_nop_sel", nop_sel, 1);
    step();
    flush = 1'b0;
    settle();
    chk("fl_bubble", stg_valid[0], 0);
    chk("fl_rd1", stg_rd[9:5], 21);
    chk("fl_rd2", stg_rd[14:10], 20);
    step();

    // freeze during a load-use
    put(mk(1'b1, 1'b1), 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    put(mk(1'b0, 1'b1), 1'b1, 5'd10, 5'd9, 5'd0, 1'b1, 1'b0);
    ext_stall = 1'b1;
    snap = int'(cnt16);
    settle();
    chk("fz_pc_le", pc_le, 0);
    chk("fz_nop_sel", nop_sel, 0);
    repeat (3) step();
    chk("fz_cnt_hold", stall_cnt, snap);
    chk("fz_rd0", stg_rd[4:0], 9);
    ext_stall = 1'b0;
    settle();
    chk("fz_haz_nop", nop_sel, 1);
    step();
    settle();
    chk("fz_cnt_inc", stall_cnt, snap + 1);
    chk("fz_bubble", stg_valid[0], 0);
    step();
    settle();
    chk("fz_add_in", stg_rd[4:0], 10);

    // saturation: 20 load-use hazards after reset
    Reset = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      put(mk(1'b1, 1'b1), 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      put(mk(1'b0, 1'b1), 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
      step();
      step();
    end
    settle();
    chk("sat_w4", s_stall_cnt, 4'hF);
    chk("sat_w16", stall_cnt, 20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      put(mk($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      Reset     = ($urandom_range(0, 49) == 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
